// File: rtl/lampFPU_pkg.sv
// Shared LAMP FPU constants and types used by the sqrt post-processing stage.
package lampFPU_pkg;

  localparam int unsigned LAMP_FLOAT_E_DW   = 8;
  localparam int unsigned LAMP_FLOAT_F_DW   = 7;
  localparam int unsigned LAMP_ROUND_GRS_DW = 4;

  localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] INF_E_F =
    {{LAMP_FLOAT_E_DW{1'b1}}, {LAMP_FLOAT_F_DW{1'b0}}};
  localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] ZERO_E_F = '0;

  typedef struct packed {
    logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW:0] result;
    logic                                     inexact;
    logic                                     overflow;
  } sqrtRoundEntry_t;

endpackage

// File: rtl/lampfpu_round_fifo.sv
// DEPTH-entry FIFO of rounded sqrt results; push and pop may coincide at any
// occupancy, including full.
module lampfpu_round_fifo
  import lampFPU_pkg::*;
#(
  parameter type         T     = sqrtRoundEntry_t,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  T                           data,
  output T                           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T               mem [DEPTH];
  logic [AW-1:0]  wrPtr;
  logic [AW-1:0]  rdPtr;
  logic           doPush;
  logic           doPop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign doPop  = pop & ~empty;
  // A full queue still accepts a beat when the head leaves in the same cycle.
  assign doPush = push & (~full | doPop);
  assign head   = mem[rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush & ~doPop)      count <= count + 1'b1;
      else if (doPop & ~doPush) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= data;
  end

endmodule

// File: rtl/lampfpu_sqrt_round.sv
// Sqrt result rounding (RNE), renormalisation, saturation and output queueing.
// Optional sticky status flags: define LAMPFPU_ROUND_STATUS_EN.
module lampfpu_sqrt_round
  import lampFPU_pkg::*;
#(
  parameter int unsigned E_DW  = LAMP_FLOAT_E_DW,
  parameter int unsigned F_DW  = LAMP_FLOAT_F_DW,
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic                 s_i,
  input  logic [E_DW-1:0]      e_i,
  input  logic [F_DW+4:0]      f_i,
  input  logic                 isToRound_i,
  input  logic                 isOverflow_i,
  input  logic                 isUnderflow_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [E_DW+F_DW:0]   result_o,
  output logic                 inexact_o,
  output logic                 overflow_o,
  output logic                 drop_o
`ifdef LAMPFPU_ROUND_STATUS_EN
  ,
  input  logic                 flags_clr_i,
  output logic [2:0]           flags_o
`endif
);

  localparam int unsigned MW = F_DW + 1 + LAMP_ROUND_GRS_DW;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [E_DW+F_DW:0] result;
    logic               inexact;
    logic               overflow;
  } entry_t;

  logic            vA;
  logic            sA;
  logic [E_DW-1:0] eA;
  logic [MW-1:0]   fA;
  logic            trA;
  logic            ovA;
  logic            unA;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vA <= 1'b0;
    else     vA <= valid_i;
  end

  always_ff @(posedge clk) begin
    sA  <= s_i;
    eA  <= e_i;
    fA  <= f_i;
    trA <= isToRound_i;
    ovA <= isOverflow_i;
    unA <= isUnderflow_i;
  end

  logic            lsb;
  logic            g;
  logic            st;
  logic            rnd;
  logic [F_DW+1:0] m;
  logic [E_DW:0]   expW;
  logic [F_DW-1:0] frac;
  entry_t          entB;
  logic            unusedHidden;

  assign unusedHidden = m[F_DW];

  always_comb begin
    lsb  = fA[LAMP_ROUND_GRS_DW];
    g    = fA[LAMP_ROUND_GRS_DW-1];
    st   = |fA[LAMP_ROUND_GRS_DW-2:0];
    rnd  = trA & g & (st | lsb);
    m    = {1'b0, fA[MW-1:LAMP_ROUND_GRS_DW]} + {{(F_DW+1){1'b0}}, rnd};
    frac = m[F_DW-1:0];
    expW = {1'b0, eA};
    if (m[F_DW+1]) begin
      frac = '0;
      expW = {1'b0, eA} + {{E_DW{1'b0}}, 1'b1};
    end
    entB.result   = {sA, expW[E_DW-1:0], frac};
    entB.inexact  = trA & (g | st);
    entB.overflow = 1'b0;
    // Exponent is widened so a carry out of an all-ones exponent still saturates.
    if (ovA | (trA & (expW >= {1'b0, {E_DW{1'b1}}}))) begin
      entB.result   = {sA, {E_DW{1'b1}}, {F_DW{1'b0}}};
      entB.inexact  = 1'b1;
      entB.overflow = 1'b1;
    end else if (unA) begin
      entB.result   = {sA, {(E_DW+F_DW){1'b0}}};
      entB.inexact  = 1'b1;
    end else if (!trA) begin
      entB.result   = {sA, eA, fA[MW-2:LAMP_ROUND_GRS_DW]};
      entB.inexact  = 1'b0;
    end
  end

  entry_t          headE;
  logic            full;
  logic            empty;
  logic [CW-1:0]   unusedCount;
  logic            popQ;
  logic            dropEvent;

  lampfpu_round_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vA),
    .pop   (popQ),
    .data  (entB),
    .head  (headE),
    .full  (full),
    .empty (empty),
    .count (unusedCount)
  );

  assign valid_o    = ~empty;
  assign popQ       = valid_o & ready_i;
  assign dropEvent  = vA & full & ~popQ;
  assign result_o   = valid_o ? headE.result   : '0;
  assign inexact_o  = valid_o & headE.inexact;
  assign overflow_o = valid_o & headE.overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            drop_o <= 1'b0;
    else if (dropEvent) drop_o <= 1'b1;
  end

`ifdef LAMPFPU_ROUND_STATUS_EN
  // New events land after the clear so a coincident set survives it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_o <= '0;
    else     flags_o <= (flags_clr_i ? 3'b000 : flags_o) |
                        {popQ & headE.overflow, popQ & headE.inexact, dropEvent};
  end
`endif

endmodule

// File: tb/tb_lampfpu_sqrt_round.sv
// Scoreboard bench for lampfpu_sqrt_round with default widths (E_DW=8, F_DW=7).
module tb_lampfpu_sqrt_round;
  import lampFPU_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        s_i = 1'b0;
  logic [7:0]  e_i = '0;
  logic [11:0] f_i = '0;
  logic        isToRound_i = 1'b0;
  logic        isOverflow_i = 1'b0;
  logic        isUnderflow_i = 1'b0;
  logic        ready_i = 1'b0;
  logic        valid_o;
  logic [15:0] result_o;
  logic        inexact_o;
  logic        overflow_o;
  logic        drop_o;
`ifdef LAMPFPU_ROUND_STATUS_EN
  logic        flags_clr_i = 1'b0;
  logic [2:0]  flags_o;
`endif

  int checks = 0;
  int failures = 0;
  logic [17:0] sbq[$];

  lampfpu_sqrt_round #(.E_DW(8), .F_DW(7), .DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .s_i           (s_i),
    .e_i           (e_i),
    .f_i           (f_i),
    .isToRound_i   (isToRound_i),
    .isOverflow_i  (isOverflow_i),
    .isUnderflow_i (isUnderflow_i),
    .ready_i       (ready_i),
    .valid_o       (valid_o),
    .result_o      (result_o),
    .inexact_o     (inexact_o),
    .overflow_o    (overflow_o),
    .drop_o        (drop_o)
`ifdef LAMPFPU_ROUND_STATUS_EN
    ,
    .flags_clr_i   (flags_clr_i),
    .flags_o       (flags_o)
`endif
  );

  always #5 clk = ~clk;

  // Reference: integer RNE on the 8-bit significand, remainder over 16.
  function automatic logic [17:0] model(input logic s, input logic [7:0] e,
                                        input logic [11:0] f, input logic tr,
                                        input logic ov, input logic un);
    int mant;
    int rem;
    int ex;
    logic [7:0] f8;
    logic [3:0] f4;
    if (ov) return {s, INF_E_F, 2'b11};
    if (un) return {s, ZERO_E_F, 2'b10};
    if (!tr) return {s, e, f[10:4], 2'b00};
    f8 = f[11:4];
    f4 = f[3:0];
    mant = int'(f8);
    rem = int'(f4);
    ex = int'(e);
    if (rem > 8 || (rem == 8 && (mant % 2) == 1)) mant++;
    if (mant == 256) begin
      mant = 128;
      ex++;
    end
    if (ex >= 255) return {s, INF_E_F, 2'b11};
    return {s, 8'(ex), 7'(mant), (rem != 0), 1'b0};
  endfunction

  // Called just after a rising edge; returns just after the next one.
  task automatic sendBeat(input logic s, input logic [7:0] e, input logic [11:0] f,
                          input logic tr, input logic ov, input logic un, input bit keep);
    s_i = s; e_i = e; f_i = f;
    isToRound_i = tr; isOverflow_i = ov; isUnderflow_i = un;
    valid_i = 1'b1;
    if (keep) sbq.push_back(model(s, e, f, tr, ov, un));
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({valid_o, result_o, inexact_o, overflow_o, drop_o} !== 20'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {valid_o, result_o, inexact_o, overflow_o, drop_o});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic s; logic [7:0] e; logic [11:0] f; logic tr; logic ov; logic un;
    logic [15:0] res; logic inx; logic ovf;
  } vec_t;

  task automatic test_rounding();
    vec_t tbl[9] = '{
      '{1'b0, 8'h7F, 12'b1_0000001_1000, 1'b1, 1'b0, 1'b0, 16'h3F82, 1'b1, 1'b0},
      '{1'b0, 8'h7F, 12'b1_1111111_1001, 1'b1, 1'b0, 1'b0, 16'h4000, 1'b1, 1'b0},
      '{1'b0, 8'hFE, 12'b1_1111111_1100, 1'b1, 1'b0, 1'b0, 16'h7F80, 1'b1, 1'b1},
      '{1'b0, 8'hFF, 12'b1_1000000_0000, 1'b0, 1'b0, 1'b0, 16'h7FC0, 1'b0, 1'b0},
      '{1'b1, 8'h80, 12'b1_0000000_1000, 1'b1, 1'b0, 1'b0, 16'hC000, 1'b1, 1'b0},
      '{1'b0, 8'h10, 12'b1_0000000_1001, 1'b1, 1'b0, 1'b0, 16'h0801, 1'b1, 1'b0},
      '{1'b0, 8'h7F, 12'b1_0101010_0000, 1'b1, 1'b0, 1'b0, 16'h3FAA, 1'b0, 1'b0},
      '{1'b1, 8'h01, 12'b1_0000000_1111, 1'b1, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0},
      '{1'b1, 8'h40, 12'b1_0000000_0000, 1'b1, 1'b1, 1'b1, 16'hFF80, 1'b1, 1'b1}
    };
    ready_i = 1'b1;
    foreach (tbl[i]) begin
      sendBeat(tbl[i].s, tbl[i].e, tbl[i].f, tbl[i].tr, tbl[i].ov, tbl[i].un, 1'b0);
      checks++;
      if (valid_o !== 1'b0) begin
        failures++;
        $display("FAIL latency_early case=%0d valid_o=%b want=0", i, valid_o);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({valid_o, result_o, inexact_o, overflow_o} !== {1'b1, tbl[i].res, tbl[i].inx, tbl[i].ovf}) begin
        failures++;
        $display("FAIL round_case%0d got v=%b r=%h i=%b o=%b want v=1 r=%h i=%b o=%b",
                 i, valid_o, result_o, inexact_o, overflow_o, tbl[i].res, tbl[i].inx, tbl[i].ovf);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (valid_o !== 1'b0) begin
      failures++;
      $display("FAIL round_drain valid_o=%b want=0", valid_o);
    end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    ready_i = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          logic ov;
          logic un;
          ov = ($urandom_range(0, 9) == 0);
          un = ($urandom_range(0, 9) == 0);
          sendBeat(1'($urandom), 8'($urandom_range(0, 254)), {1'b1, 11'($urandom)},
                   ($urandom_range(0, 5) != 0), ov, un, 1'b1);
        end
      end
      begin
        for (int c = 0; c < 40 && got < 12; c++) begin
          @(negedge clk);
          if (valid_o && ready_i) begin
            logic [17:0] ex;
            ex = sbq.pop_front();
            checks++;
            if ({result_o, inexact_o, overflow_o} !== ex) begin
              failures++;
              $display("FAIL b2b_beat%0d got r=%h i=%b o=%b want r=%h i=%b o=%b",
                       got, result_o, inexact_o, overflow_o, ex[17:2], ex[1], ex[0]);
            end
            got++;
          end
        end
      end
    join
    checks++;
    if (got != 12) begin
      failures++;
      $display("FAIL b2b_timeout got=%0d want=12", got);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_push_pop();
    int got = 0;
    ready_i = 1'b0;
    sendBeat(1'b0, 8'h20, 12'b1_0000011_0001, 1'b1, 1'b0, 1'b0, 1'b1);
    sendBeat(1'b1, 8'h30, 12'b1_0000101_1010, 1'b1, 1'b0, 1'b0, 1'b1);
    sendBeat(1'b0, 8'h50, 12'b1_1110000_1000, 1'b1, 1'b0, 1'b0, 1'b1);
    // Queue is full now; the third beat arrives on the same edge as the first pop.
    ready_i = 1'b1;
    for (int c = 0; c < 10 && got < 3; c++) begin
      @(negedge clk);
      if (valid_o && ready_i) begin
        logic [17:0] ex;
        ex = sbq.pop_front();
        checks++;
        if ({result_o, inexact_o, overflow_o} !== ex) begin
          failures++;
          $display("FAIL fullpp_beat%0d got r=%h i=%b o=%b want r=%h i=%b o=%b",
                   got, result_o, inexact_o, overflow_o, ex[17:2], ex[1], ex[0]);
        end
        got++;
      end
    end
    checks++;
    if (got != 3 || drop_o !== 1'b0) begin
      failures++;
      $display("FAIL fullpp_nodrop got=%0d drop_o=%b want 3 and 0", got, drop_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int got = 0;
    logic [15:0] held;
    ready_i = 1'b0;
    sendBeat(1'b0, 8'h11, 12'b1_0000001_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    sendBeat(1'b1, 8'h22, 12'b1_0000010_1100, 1'b1, 1'b0, 1'b0, 1'b1);
    sendBeat(1'b0, 8'h33, 12'b1_0000011_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if ({valid_o, drop_o, result_o} !== {1'b1, 1'b1, sbq[0][17:2]}) begin
      failures++;
      $display("FAIL bp_full got v=%b d=%b r=%h want v=1 d=1 r=%h", valid_o, drop_o, result_o, sbq[0][17:2]);
    end
    held = result_o;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (result_o !== sbq[0][17:2] || valid_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_stable got v=%b r=%h want v=1 r=%h (was %h)", valid_o, result_o, sbq[0][17:2], held);
    end
    ready_i = 1'b1;
    for (int c = 0; c < 10 && got < 2; c++) begin
      @(negedge clk);
      if (valid_o && ready_i) begin
        logic [17:0] ex;
        ex = sbq.pop_front();
        checks++;
        if ({result_o, inexact_o, overflow_o} !== ex) begin
          failures++;
          $display("FAIL bp_beat%0d got r=%h i=%b o=%b want r=%h i=%b o=%b",
                   got, result_o, inexact_o, overflow_o, ex[17:2], ex[1], ex[0]);
        end
        got++;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (got != 2 || valid_o !== 1'b0 || drop_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_after got=%0d v=%b d=%b want 2 0 1", got, valid_o, drop_o);
    end
  endtask

  task automatic test_async_reset();
    ready_i = 1'b0;
    sendBeat(1'b0, 8'h44, 12'b1_0000001_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    sendBeat(1'b0, 8'h45, 12'b1_0000001_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    sendBeat(1'b0, 8'h46, 12'b1_0000001_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (valid_o !== 1'b1 || drop_o !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre v=%b d=%b want 1 1", valid_o, drop_o);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({valid_o, drop_o, result_o, inexact_o, overflow_o} !== 20'h0) begin
      failures++;
      $display("FAIL arst_clear got v=%b d=%b r=%h i=%b o=%b want all 0",
               valid_o, drop_o, result_o, inexact_o, overflow_o);
    end
    sbq.delete();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    sendBeat(1'b1, 8'h7F, 12'b1_0000001_1000, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (valid_o !== 1'b0) begin
      failures++;
      $display("FAIL arst_latency_early valid_o=%b want=0", valid_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (valid_o !== 1'b1 || sbq.size() != 1 || {result_o, inexact_o, overflow_o} !== sbq[0]) begin
      failures++;
      $display("FAIL arst_first got v=%b r=%h i=%b o=%b want v=1 r=BF82 i=1 o=0",
               valid_o, result_o, inexact_o, overflow_o);
    end
    if (sbq.size() != 0) void'(sbq.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_back_to_back();
    test_full_push_pop();
    test_backpressure();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
